stage_seq: RTL and testbench
============================

// Module: stage_seq
// PURPOSE
//  Parametrised multi-cycle stage sequencer for the RK16 core; successor of the fixed 4-stage generator.
//  Emits one-cycle stage enables (no derived clocks) that gate rs1/rs2 latches, mem strobe, PC update.
//  Adds memory wait handshake, per-instruction stage skipping, interrupt entry at instruction
//  boundary, halt/single-step and wait-timeout fault. Sits between id (skip mask) and pfc/mem.
// PARAMETERS
//  NSTAGE    4        number of stages per instruction (>=2); stage NSTAGE-1 is PC update
//  WAIT_MASK 4'b0100  stages that wait on mem_ready (bit i = stage i); bit NSTAGE-1 ignored
//  WAIT_MAX  0        max wait cycles per stage before fault; 0 = no timeout
// PORTS
//  clk        in   1          core clock
//  rst_n      in   1          async active-low reset
//  skip_mask  in   NSTAGE     from id: stage i skipped this instruction; bit NSTAGE-1 ignored
//  mem_ready  in   1          memory completes current access this cycle
//  irq        in   1          level interrupt request
//  irq_en     in   1          interrupt enable
//  halt_req   in   1          stop at next instruction boundary
//  step       in   1          single-step mode: halt after every instruction
//  run        in   1          one-cycle pulse: leave HALT
//  stage      out  $clog2(NSTAGE)  current stage index
//  stg_en     out  NSTAGE     one-hot, one-cycle enable of the executing stage
//  mem_req    out  1          high while current stage is in WAIT_MASK and not completed
//  boot_en    out  1          one-cycle pulse after reset: pfc loads reset vector
//  intr_en    out  1          one-cycle pulse: pfc takes interrupt vector, saves ira
//  instr_done out  1          pulse with stg_en[NSTAGE-1]
//  halted     out  1          in HALT
//  fault      out  1          sticky wait timeout; cleared only by reset
// BEHAVIOUR
//  States: BOOT, RUN, INTR, HALT. Reset: state=BOOT, stage=0, every output 0, wait_cnt=0.
//  BOOT: first clk edge after rst_n high -> boot_en=1 for that cycle; next state RUN at first active stage.
//  RUN, non-wait stage s: stg_en[s]=1 for exactly one cycle, then next active stage.
//  Next active stage = lowest i>s with skip_mask[i]==0; NSTAGE-1 always active. Skipped stages use 0 cycles.
//  Stage 0 entry also honours skip_mask (first active stage = lowest unskipped index).
//  RUN, wait stage s: mem_req=1 from entry; stg_en[s]=1 only in the cycle mem_ready=1, then advance.
//   mem_ready outside a wait stage is ignored. wait_cnt counts cycles with mem_req=1 && !mem_ready,
//   cleared on stage advance. WAIT_MAX>0 && wait_cnt==WAIT_MAX -> fault=1, mem_req=0, go HALT.
//  Boundary (cycle with stg_en[NSTAGE-1]): instr_done=1. Next state priority:
//   irq&&irq_en -> INTR; else halt_req||step -> HALT; else RUN at first active stage.
//  INTR: intr_en=1 one cycle, stg_en=0; then halt_req||step -> HALT, else RUN at first active stage.
//  HALT: halted=1, stg_en=0, mem_req=0, stage=0. run pulse (and !fault) -> RUN at first active stage.
//   run ignored while fault=1. irq does not wake HALT.
//  run outside HALT ignored; halt_req mid-instruction waits for boundary (no instruction is split).
//  Async reset mid-instruction/mid-wait: immediate return to reset values; partial instruction discarded.
//  Latency: instruction with k active non-waiting stages = k cycles; +w per waited cycle.
// STRUCTURE
//  rk_stage_pkg: state_t enum {BOOT,RUN,INTR,HALT}; function for stage index width;
//   localparam LAST_STAGE = NSTAGE-1.
//  One sub-module natural: stage_wdog (wait counter + WAIT_MAX compare, sticky fault); width $clog2(WAIT_MAX+1).
//  Next-active-stage priority encoder stays inline (combinational function in package).
// TESTING
//  1 Reset release, NSTAGE=4, skip=0, mem_ready=1 -> boot_en @cyc1, stg_en 0001,0010,0100,1000 repeating, instr_done every 4th.
//  2 mem_ready low 3 cycles in stage 2 -> mem_req high 4 cycles, stg_en[2] only in 4th, instruction = 7 cycles.
//  3 skip_mask=4'b0010 -> stg_en 0001,0100,1000; 3 cycles/instr; skip_mask=4'b1111 -> only 1000 each cycle.
//  4 irq=1,irq_en=1 asserted mid-stage 1 -> completes stage 2,3; intr_en one cycle after instr_done; then stage 0.
//  5 irq+halt_req at same boundary -> intr_en, then halted=1; run pulse -> stage 0 resumes; step=1 -> halts after 1 instr.
//  6 WAIT_MAX=5, mem_ready stuck low -> fault=1 after 5 wait cycles, halted=1, run ignored; rst_n low mid-wait -> all outputs 0.

Source files
------------

// File: rtl/rk_stage_pkg.sv
// Shared types and helpers for the RK16 stage sequencer: controller states,
// stage index sizing and the "next active stage" priority encoder.
package rk_stage_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    INTR,
    HALT
  } state_t;

  // Widest stage count the priority encoder is built for.
  localparam int unsigned MAX_STAGES = 32;

  // Width of a stage index for an nstage-deep sequence (at least one bit).
  function automatic int unsigned stage_idx_w(input int unsigned nstage);
    return (nstage <= 2) ? 1 : $clog2(nstage);
  endfunction

  // Lowest stage index >= from_idx whose skip bit is clear. The last stage
  // (PC update) can never be skipped, so it is the fallback.
  function automatic int unsigned next_active(input int unsigned from_idx,
                                               input logic [MAX_STAGES-1:0] skip,
                                               input int unsigned nstage);
    int unsigned result;
    logic        found;
    result = nstage - 1;
    found  = 1'b0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (!found && (i >= from_idx) && (i + 1 < nstage) && !skip[i]) begin
        result = i;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stage_wdog.sv
// Wait watchdog: counts consecutive cycles a memory wait stage has been
// stalled and raises a sticky fault once the stall reaches WAIT_MAX.
module stage_wdog #(
  parameter int unsigned WAIT_MAX = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic trip,
  output logic fault
);

  localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             fault_q;
  logic             fault_d;

  // Count stalled cycles, clear on any non-stalled cycle, latch the fault.
  always_comb begin
    trip       = (WAIT_MAX != 0) && (wait_cnt_q == CNT_W'(WAIT_MAX));
    wait_cnt_d = ((WAIT_MAX != 0) && waiting) ? wait_cnt_q + CNT_W'(1) : '0;
    fault_d    = fault_q || trip;
    fault      = fault_q || trip;
  end

  // Counter and sticky fault registers; only reset clears the fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: rtl/stage_seq.sv
// Multi-cycle stage sequencer for the RK16 core. Emits one-cycle stage
// enables, handles memory wait stages, per-instruction stage skipping,
// interrupt entry at instruction boundaries, halt/single-step and a
// wait-timeout fault.
module stage_seq
  import rk_stage_pkg::*;
#(
  parameter int unsigned       NSTAGE    = 4,
  parameter logic [NSTAGE-1:0] WAIT_MASK = 4'b0100,
  parameter int unsigned       WAIT_MAX  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NSTAGE-1:0]                skip_mask,
  input  logic                             mem_ready,
  input  logic                             irq,
  input  logic                             irq_en,
  input  logic                             halt_req,
  input  logic                             step,
  input  logic                             run,
  output logic [stage_idx_w(NSTAGE)-1:0]   stage,
  output logic [NSTAGE-1:0]                stg_en,
  output logic                             mem_req,
  output logic                             boot_en,
  output logic                             intr_en,
  output logic                             instr_done,
  output logic                             halted,
  output logic                             fault
);

  localparam int unsigned SW         = stage_idx_w(NSTAGE);
  localparam int unsigned LAST_STAGE = NSTAGE - 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [SW-1:0]           stage_q;
  logic [SW-1:0]           stage_d;
  logic                    boot_en_q;
  logic                    boot_en_d;

  logic [MAX_STAGES-1:0]   skip_ext;
  logic [SW-1:0]           first_stage;
  logic [SW-1:0]           next_stage;
  logic                    wait_stage;
  logic                    is_last;
  logic [NSTAGE-1:0]       stage_onehot;
  logic                    wdog_trip;

  // Skip-mask decoding: where a new instruction starts and where this one goes next.
  always_comb begin
    skip_ext     = MAX_STAGES'(skip_mask);
    first_stage  = SW'(next_active(32'd0, skip_ext, NSTAGE));
    next_stage   = SW'(next_active(32'(stage_q) + 32'd1, skip_ext, NSTAGE));
    is_last      = (stage_q == SW'(LAST_STAGE));
    wait_stage   = WAIT_MASK[stage_q] && !is_last;
    stage_onehot = NSTAGE'(1) << stage_q;
  end

  stage_wdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (mem_req && !mem_ready),
    .trip    (wdog_trip),
    .fault   (fault)
  );

  // Next-state and output decode; boundary decisions are taken only at the last stage.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    boot_en_d  = 1'b0;
    stg_en     = '0;
    mem_req    = 1'b0;
    intr_en    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      BOOT: begin
        if (!boot_en_q) begin
          boot_en_d = 1'b1;
        end else begin
          state_d = RUN;
          stage_d = first_stage;
        end
      end
      RUN: begin
        if (wait_stage && wdog_trip) begin
          state_d = HALT;
          stage_d = '0;
        end else if (wait_stage) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            stg_en  = stage_onehot;
            stage_d = next_stage;
          end
        end else begin
          stg_en = stage_onehot;
          if (is_last) begin
            instr_done = 1'b1;
            if (irq && irq_en) begin
              state_d = INTR;
              stage_d = '0;
            end else if (halt_req || step) begin
              state_d = HALT;
              stage_d = '0;
            end else begin
              stage_d = first_stage;
            end
          end else begin
            stage_d = next_stage;
          end
        end
      end
      INTR: begin
        intr_en = 1'b1;
        if (halt_req || step) begin
          state_d = HALT;
          stage_d = '0;
        end else begin
          state_d = RUN;
          stage_d = first_stage;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (run && !fault) begin
          state_d = RUN;
          stage_d = first_stage;
        end
      end
      default: begin
        state_d = BOOT;
        stage_d = '0;
      end
    endcase
  end

  // Controller registers; reset discards any partially executed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      stage_q   <= '0;
      boot_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      boot_en_q <= boot_en_d;
    end
  end

  assign stage   = stage_q;
  assign boot_en = boot_en_q;

endmodule

// File: tb/tb_stage_seq.sv
// Bench for stage_seq: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the sequencing rules.
module tb_stage_seq;

  localparam int         NS    = 4;
  localparam logic [3:0] WMASK = 4'b0100;
  localparam int         WMAX  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] skip_mask;
  logic       mem_ready;
  logic       irq;
  logic       irq_en;
  logic       halt_req;
  logic       step;
  logic       run;
  logic [1:0] stage;
  logic [3:0] stg_en;
  logic       mem_req;
  logic       boot_en;
  logic       intr_en;
  logic       instr_done;
  logic       halted;
  logic       fault;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 = waiting for first edge, 1 = boot pulse, 2 = executing,
  // 3 = interrupt entry, 4 = stopped.
  int m_phase;
  int m_cur;
  int m_waited;
  bit m_fault;

  typedef struct packed {
    logic [1:0] stage;
    logic [3:0] stg_en;
    logic       mem_req;
    logic       boot_en;
    logic       intr_en;
    logic       instr_done;
    logic       halted;
    logic       fault;
  } obs_t;

  stage_seq #(
    .NSTAGE    (NS),
    .WAIT_MASK (WMASK),
    .WAIT_MAX  (WMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .skip_mask  (skip_mask),
    .mem_ready  (mem_ready),
    .irq        (irq),
    .irq_en     (irq_en),
    .halt_req   (halt_req),
    .step       (step),
    .run        (run),
    .stage      (stage),
    .stg_en     (stg_en),
    .mem_req    (mem_req),
    .boot_en    (boot_en),
    .intr_en    (intr_en),
    .instr_done (instr_done),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // First unskipped stage after s; the last stage is always present.
  function automatic int activeAfter(input int s, input logic [3:0] mask);
    int act[$];
    for (int i = 0; i < NS; i++) begin
      if (i == NS - 1 || !mask[i]) act.push_back(i);
    end
    foreach (act[k]) begin
      if (act[k] > s) return act[k];
    end
    return NS - 1;
  endfunction

  task automatic applyStimulus(input logic [3:0] skip, input logic ready, input logic irq_i,
                               input logic irq_en_i, input logic halt_i, input logic step_i,
                               input logic run_i);
    skip_mask = skip;
    mem_ready = ready;
    irq       = irq_i;
    irq_en    = irq_en_i;
    halt_req  = halt_i;
    step      = step_i;
    run       = run_i;
  endtask

  // Predict this cycle's outputs, compare, then advance the model by one edge.
  task automatic checkOutput(input string tag);
    obs_t exp_o;
    obs_t got_o;
    int   nxt_phase;
    int   nxt_cur;
    int   nxt_wait;
    bit   nxt_fault;
    bit   stop_next;
    exp_o     = '0;
    nxt_phase = m_phase;
    nxt_cur   = m_cur;
    nxt_wait  = 0;
    nxt_fault = m_fault;
    stop_next = halt_req || step;
    if (!rst_n) begin
      nxt_phase = 0;
      nxt_cur   = 0;
      nxt_fault = 1'b0;
    end else begin
      case (m_phase)
        0: nxt_phase = 1;
        1: begin
          exp_o.boot_en = 1'b1;
          nxt_phase     = 2;
          nxt_cur       = activeAfter(-1, skip_mask);
        end
        2: begin
          exp_o.stage = 2'(m_cur);
          if (WMASK[m_cur] && m_cur != NS - 1) begin
            if (m_waited == WMAX) begin
              exp_o.fault = 1'b1;
              nxt_fault   = 1'b1;
              nxt_phase   = 4;
              nxt_cur     = 0;
            end else begin
              exp_o.mem_req = 1'b1;
              if (mem_ready) begin
                exp_o.stg_en[m_cur] = 1'b1;
                nxt_cur = activeAfter(m_cur, skip_mask);
              end else begin
                nxt_wait = m_waited + 1;
              end
            end
          end else begin
            exp_o.stg_en[m_cur] = 1'b1;
            if (m_cur == NS - 1) begin
              exp_o.instr_done = 1'b1;
              if (irq && irq_en) begin
                nxt_phase = 3;
                nxt_cur   = 0;
              end else if (stop_next) begin
                nxt_phase = 4;
                nxt_cur   = 0;
              end else begin
                nxt_cur = activeAfter(-1, skip_mask);
              end
            end else begin
              nxt_cur = activeAfter(m_cur, skip_mask);
            end
          end
        end
        3: begin
          exp_o.intr_en = 1'b1;
          nxt_phase     = stop_next ? 4 : 2;
          nxt_cur       = stop_next ? 0 : activeAfter(-1, skip_mask);
        end
        default: begin
          exp_o.halted = 1'b1;
          if (run && !m_fault) begin
            nxt_phase = 2;
            nxt_cur   = activeAfter(-1, skip_mask);
          end
        end
      endcase
      exp_o.fault = exp_o.fault | m_fault;
    end
    got_o = {stage, stg_en, mem_req, boot_en, intr_en, instr_done, halted, fault};
    checks++;
    assert (got_o === exp_o)
    else begin
      failures++;
      $error("[TB] FAIL %s got={stage,stg_en,req,boot,intr,done,halt,fault}=%b required=%b",
             tag, got_o, exp_o);
    end
    m_phase  = nxt_phase;
    m_cur    = nxt_cur;
    m_waited = nxt_wait;
    m_fault  = nxt_fault;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilStage(input int target);
    int n;
    n = 0;
    while (!(m_phase == 2 && m_cur == target) && n < 50) begin
      cycle("seek");
      n++;
    end
    if (n == 50) begin
      checks++;
      failures++;
      $error("[TB] FAIL seek_stage got=timeout required=stage %0d within 50 cycles", target);
    end
  endtask

  initial begin
    m_phase  = 0;
    m_cur    = 0;
    m_waited = 0;
    m_fault  = 1'b0;
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    repeat (2) cycle("in_reset");
    rst_n = 1'b1;

    $display("[TB] free run after reset");
    repeat (14) cycle("free_run");

    $display("[TB] memory wait in stage 2");
    runUntilStage(2);
    mem_ready = 1'b0;
    repeat (3) cycle("mem_wait");
    mem_ready = 1'b1;
    repeat (6) cycle("mem_wait_done");

    $display("[TB] stage skipping");
    skip_mask = 4'b0010;
    repeat (9) cycle("skip_0010");
    skip_mask = 4'b1111;
    repeat (5) cycle("skip_1111");
    skip_mask = 4'b0000;
    repeat (2) cycle("skip_clear");

    $display("[TB] interrupt entry");
    runUntilStage(1);
    irq = 1'b1;
    irq_en = 1'b1;
    repeat (6) cycle("irq_entry");
    irq = 1'b0;
    repeat (2) cycle("irq_after");

    $display("[TB] irq with halt, run, step");
    runUntilStage(3);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("irq_halt_boundary");
    irq = 1'b0;
    cycle("irq_halt_intr");
    halt_req = 1'b0;
    repeat (3) cycle("halted_idle");
    run = 1'b1;
    cycle("run_pulse");
    run = 1'b0;
    run = 1'b1;
    cycle("run_ignored_in_run");
    run = 1'b0;
    halt_req = 1'b1;
    repeat (5) cycle("halt_mid_instr");
    halt_req = 1'b0;
    step = 1'b1;
    run = 1'b1;
    cycle("step_resume");
    run = 1'b0;
    repeat (6) cycle("step_halt");
    step = 1'b0;
    run = 1'b1;
    cycle("step_off_resume");
    run = 1'b0;
    repeat (3) cycle("resumed");

    $display("[TB] wait timeout fault");
    runUntilStage(2);
    mem_ready = 1'b0;
    repeat (8) cycle("timeout");
    run = 1'b1;
    repeat (2) cycle("run_while_fault");
    run = 1'b0;
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("fault_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle("after_fault_reset");

    $display("[TB] async reset mid-wait");
    runUntilStage(2);
    mem_ready = 1'b0;
    repeat (2) cycle("pre_async_rst");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst");
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    repeat (2) cycle("held_reset");
    rst_n = 1'b1;
    repeat (6) cycle("post_reset");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom), ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 10),
                    1'($urandom), ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 4),
                    ($urandom_range(0, 99) < 25));
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
